// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with pulse (MODE 0) or streaming valid/ready (MODE 1) handshakes.
// Optional high-water tracking is built when SYNC_FIFO_WATERMARK_EN is defined.
module sync_fifo_param #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 128,
  parameter int MODE         = 0,
  parameter int AFULL_LEVEL  = DEPTH - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                     comm_clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_full,
  output logic                     in_almost_full,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_empty,
  output logic                     out_almost_empty,
`ifdef SYNC_FIFO_WATERMARK_EN
  output logic [$clog2(DEPTH):0]   high_water,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_LV  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LV  = LW'(AFULL_LEVEL);
  localparam logic [LW-1:0] AEMPTY_LV = LW'(AEMPTY_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wr_ptr;
  logic [LW-1:0]    rd_ptr;
  logic [LW-1:0]    level_next;
  logic             mem_empty;
  logic             wr_fire;
  logic             rd_fire;
  logic             pop_mem;

  // Handshake semantics:
  //   MODE 0: a write is taken when in_valid is high, in_ready is low and the FIFO is
  //   not full; in_ready then pulses for one cycle as the acknowledge. A read request
  //   (out_ready) pops the head when out_valid is low and the FIFO is not empty, and
  //   out_valid pulses for one cycle with the word.
  //   MODE 1: a word moves on every edge where valid and ready are both high on that
  //   side; in_ready is a registered copy of !in_full and out_valid/out_data form a
  //   registered head stage that refills from memory in the same edge it is consumed.
  assign mem_empty = (wr_ptr == rd_ptr);

  always_comb begin
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    pop_mem = 1'b0;
    if (MODE == 0) begin
      wr_fire = in_valid && !in_ready && !in_full;
      rd_fire = out_ready && !out_valid && !out_empty;
      pop_mem = rd_fire;
    end else begin
      wr_fire = in_valid && in_ready;
      rd_fire = out_valid && out_ready;
      pop_mem = !mem_empty && (!out_valid || out_ready);
    end
  end

  always_comb begin
    level_next = level;
    unique case ({wr_fire, rd_fire})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // Storage array carries no reset; pointers alone define which entries are live.
  always_ff @(posedge comm_clock) begin
    if (wr_fire && !flush) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + LW'(1);
      end
      if (pop_mem) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
      level <= level_next;
      if (MODE == 0) begin
        in_ready  <= wr_fire;
        out_valid <= rd_fire;
        out_data  <= rd_fire ? mem[rd_ptr[AW-1:0]] : '0;
      end else begin
        in_ready <= (level_next != DEPTH_LV);
        if (pop_mem) begin
          out_valid <= 1'b1;
          out_data  <= mem[rd_ptr[AW-1:0]];
        end else if (rd_fire) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end
      end
    end
  end

  assign in_full          = (level == DEPTH_LV);
  assign in_almost_full   = (level >= AFULL_LV);
  assign out_empty        = (level == '0);
  assign out_almost_empty = (level <= AEMPTY_LV);

`ifdef SYNC_FIFO_WATERMARK_EN
  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      high_water <= '0;
    end else if (flush) begin
      high_water <= '0;
    end else if (level > high_water) begin
      high_water <= level;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a MODE 0 byte FIFO and a MODE 1 16-bit FIFO, both depth 4.
// High-water checks are compiled in when SYNC_FIFO_WATERMARK_EN is defined.
module tb_sync_fifo_param;

  logic        clk;
  logic        reset;

  logic        flush0, in_valid0, in_ready0, in_full0, in_afull0;
  logic        out_ready0, out_valid0, out_empty0, out_aempty0;
  logic [7:0]  in_data0, out_data0;
  logic [2:0]  level0;

  logic        flush1, in_valid1, in_ready1, in_full1, in_afull1;
  logic        out_ready1, out_valid1, out_empty1, out_aempty1;
  logic [15:0] in_data1, out_data1;
  logic [2:0]  level1;

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [2:0]  hw0, hw1;
`endif

  int n_checks = 0;
  int n_err    = 0;

  sync_fifo_param #(.WIDTH(8), .DEPTH(4), .MODE(0), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)) u0 (
    .comm_clock(clk), .reset(reset), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .in_full(in_full0), .in_almost_full(in_afull0),
    .out_ready(out_ready0), .out_valid(out_valid0), .out_data(out_data0),
    .out_empty(out_empty0), .out_almost_empty(out_aempty0),
`ifdef SYNC_FIFO_WATERMARK_EN
    .high_water(hw0),
`endif
    .level(level0)
  );

  sync_fifo_param #(.WIDTH(16), .DEPTH(4), .MODE(1), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)) u1 (
    .comm_clock(clk), .reset(reset), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .in_full(in_full1), .in_almost_full(in_afull1),
    .out_ready(out_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_empty(out_empty1), .out_almost_empty(out_aempty1),
`ifdef SYNC_FIFO_WATERMARK_EN
    .high_water(hw1),
`endif
    .level(level1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // checkers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MODE 0 drivers
  task automatic wr0(input logic [7:0] d, input logic acc);
    in_valid0 = 1'b1;
    in_data0  = d;
    tick();
    chk1("m0_wr_ack", in_ready0, acc);
    in_valid0 = 1'b0;
    tick();
    chk1("m0_wr_ack_low", in_ready0, 1'b0);
  endtask

  task automatic rd0(input logic [7:0] exp, input logic v);
    out_ready0 = 1'b1;
    tick();
    chk1("m0_rd_valid", out_valid0, v);
    chk8("m0_rd_data", out_data0, v ? exp : 8'h00);
    out_ready0 = 1'b0;
    tick();
    chk1("m0_rd_valid_low", out_valid0, 1'b0);
    chk8("m0_rd_data_low", out_data0, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = 8'h00; out_ready0 = 1'b0;
    flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = 16'h0000; out_ready1 = 1'b0;
    #2;
    chk3("rst_level0", level0, 3'd0);
    chk1("rst_ready0", in_ready0, 1'b0);
    chk1("rst_valid0", out_valid0, 1'b0);
    chk8("rst_data0", out_data0, 8'h00);
    chk1("rst_empty0", out_empty0, 1'b1);
    chk1("rst_aempty0", out_aempty0, 1'b1);
    chk1("rst_full0", in_full0, 1'b0);
    chk1("rst_ready1", in_ready1, 1'b0);
    chk1("rst_valid1", out_valid1, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk1("m1_ready_after_rst", in_ready1, 1'b1);
    chk1("m0_ready_idle", in_ready0, 1'b0);

    // MODE 1 streaming: A0..A3 back to back with consumer always ready
    out_ready1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        in_valid1 = 1'b1;
        in_data1  = 16'(16'h00A0 + k);
      end else begin
        in_valid1 = 1'b0;
      end
      tick();
      chk1("m1_stream_valid", out_valid1, (k >= 1 && k <= 4));
      chk16("m1_stream_data", out_data1, (k >= 1 && k <= 4) ? 16'(16'h00A0 + k - 1) : 16'h0000);
      if (k < 4) chk1("m1_stream_ready", in_ready1, 1'b1);
    end
    out_ready1 = 1'b0;
    chk3("m1_stream_level", level1, 3'd0);
    chk1("m1_stream_empty", out_empty1, 1'b1);

    // MODE 1 fill to full, then a write while popping at full is rejected
    for (int j = 0; j < 4; j++) begin
      in_valid1 = 1'b1;
      in_data1  = 16'(16'h0B00 + j);
      tick();
      chk3("m1_fill_level", level1, 3'(j + 1));
      chk1("m1_fill_ready", in_ready1, (j < 3));
    end
    chk1("m1_full", in_full1, 1'b1);
    chk1("m1_full_head_valid", out_valid1, 1'b1);
    chk16("m1_full_head", out_data1, 16'h0B00);
    in_data1   = 16'hFFFF;
    out_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk3("m1_full_pop_level", level1, 3'd3);
    chk1("m1_full_pop_ready", in_ready1, 1'b1);
    for (int j = 1; j < 4; j++) begin
      chk1("m1_drain_valid", out_valid1, 1'b1);
      chk16("m1_drain_data", out_data1, 16'(16'h0B00 + j));
      tick();
    end
    out_ready1 = 1'b0;
    chk1("m1_drain_valid_end", out_valid1, 1'b0);
    chk16("m1_drain_data_end", out_data1, 16'h0000);
    chk3("m1_drain_level", level1, 3'd0);

    // MODE 1 flush with two words held
    in_valid1 = 1'b1;
    in_data1  = 16'h1111;
    tick();
    in_data1  = 16'h2222;
    tick();
    in_valid1 = 1'b0;
    chk3("m1_pre_flush_level", level1, 3'd2);
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    chk3("m1_flush_level", level1, 3'd0);
    chk1("m1_flush_valid", out_valid1, 1'b0);
    chk1("m1_flush_ready", in_ready1, 1'b0);
    tick();
    chk1("m1_flush_ready_back", in_ready1, 1'b1);
    chk1("m1_flush_stays_empty", out_valid1, 1'b0);

    // MODE 0: fill 11..44, reject 55, drain in order
    for (int i = 0; i < 4; i++) begin
      wr0(8'(8'h11 * (i + 1)), 1'b1);
      chk3("m0_fill_level", level0, 3'(i + 1));
      chk1("m0_fill_afull", in_afull0, (i + 1) >= 3);
      chk1("m0_fill_aempty", out_aempty0, (i + 1) <= 1);
    end
    chk1("m0_full", in_full0, 1'b1);
    in_valid0 = 1'b1;
    in_data0  = 8'h55;
    tick();
    chk1("m0_full_no_ack", in_ready0, 1'b0);
    tick();
    chk1("m0_full_no_ack2", in_ready0, 1'b0);
    chk3("m0_full_level", level0, 3'd4);
    in_valid0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd0(8'(8'h11 * (i + 1)), 1'b1);
      chk3("m0_drain_level", level0, 3'(3 - i));
    end
    chk1("m0_empty", out_empty0, 1'b1);
    chk1("m0_empty_aempty", out_aempty0, 1'b1);
    chk1("m0_empty_not_full", in_full0, 1'b0);
    rd0(8'h00, 1'b0);

    // MODE 0: interleaved pairs wrap the pointers
    for (int i = 0; i < 10; i++) begin
      wr0(8'(i), 1'b1);
      rd0(8'(i), 1'b1);
    end
    chk3("m0_wrap_level", level0, 3'd0);

    // MODE 0: simultaneous write and read at level 2
    wr0(8'h01, 1'b1);
    wr0(8'h02, 1'b1);
    in_valid0  = 1'b1;
    in_data0   = 8'h03;
    out_ready0 = 1'b1;
    tick();
    in_valid0  = 1'b0;
    out_ready0 = 1'b0;
    chk1("m0_both_ack", in_ready0, 1'b1);
    chk1("m0_both_valid", out_valid0, 1'b1);
    chk8("m0_both_data", out_data0, 8'h01);
    chk3("m0_both_level", level0, 3'd2);
    tick();
    rd0(8'h02, 1'b1);
    rd0(8'h03, 1'b1);

    // MODE 0: flush at level 3 discards a coincident write and read
    wr0(8'hA1, 1'b1);
    wr0(8'hA2, 1'b1);
    wr0(8'hA3, 1'b1);
    flush0     = 1'b1;
    in_valid0  = 1'b1;
    in_data0   = 8'hEE;
    out_ready0 = 1'b1;
    tick();
    flush0     = 1'b0;
    in_valid0  = 1'b0;
    out_ready0 = 1'b0;
    chk3("m0_flush_level", level0, 3'd0);
    chk1("m0_flush_empty", out_empty0, 1'b1);
    chk1("m0_flush_valid", out_valid0, 1'b0);
    chk8("m0_flush_data", out_data0, 8'h00);
    chk1("m0_flush_ready", in_ready0, 1'b0);
    rd0(8'h00, 1'b0);
    wr0(8'h5B, 1'b1);
    rd0(8'h5B, 1'b1);

`ifdef SYNC_FIFO_WATERMARK_EN
    wr0(8'hC1, 1'b1);
    wr0(8'hC2, 1'b1);
    wr0(8'hC3, 1'b1);
    rd0(8'hC1, 1'b1);
    rd0(8'hC2, 1'b1);
    rd0(8'hC3, 1'b1);
    chk3("wm_high", hw0, 3'd3);
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    chk3("wm_flush", hw0, 3'd0);
`endif

    // reset mid-burst clears outputs without a clock edge
    wr0(8'h61, 1'b1);
    wr0(8'h62, 1'b1);
    in_valid0 = 1'b1;
    in_data0  = 8'h63;
    tick();
    in_valid0 = 1'b0;
    chk1("m0_burst_ack", in_ready0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk3("async_rst_level", level0, 3'd0);
    chk1("async_rst_ready", in_ready0, 1'b0);
    chk1("async_rst_empty", out_empty0, 1'b1);
    tick();
    reset = 1'b0;
    wr0(8'h77, 1'b1);
    rd0(8'h77, 1'b1);
    chk1("post_rst_empty", out_empty0, 1'b1);
    chk3("post_rst_level", level0, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
